mem_write_checker: RTL and testbench

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

---
 rtl/mem_write_checker.sv | 155 +++++++++++++++
 tb/tb_mem_write_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// ============================================================================
// Module   : mem_write_checker
// Purpose  : Watches CPU stores for an ordered list of (address, data)
//            milestones and reports pass, or fail with the offending store.
//            Optional watchdog: define MEM_CHECK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_checker #(
  parameter int unsigned NUM_CHECKS     = 3,
  parameter logic [31:0] CHECK_ADDR0    = 32'd80,
  parameter logic [31:0] CHECK_ADDR1    = 32'd84,
  parameter logic [31:0] CHECK_ADDR2    = 32'd88,
  parameter logic [31:0] CHECK_ADDR3    = 32'd0,
  parameter logic [31:0] CHECK_DATA0    = 32'd7,
  parameter logic [31:0] CHECK_DATA1    = 32'd7,
  parameter logic [31:0] CHECK_DATA2    = 32'd9,
  parameter logic [31:0] CHECK_DATA3    = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  input  logic [31:0] pc,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] fail_pc,
  output logic [2:0]  hit_count,
  output logic        milestone,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ADDR    = 2'd1;
  localparam logic [1:0] CODE_DATA    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;
  localparam logic [2:0] LAST_HIT     = 3'(NUM_CHECKS);

  generate
    if (NUM_CHECKS < 1 || NUM_CHECKS > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("mem_write_checker: NUM_CHECKS must be 1..4 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t      state, state_next;
  logic [2:0]  hit_next;
  logic        milestone_next;
  logic [1:0]  code_next;
  logic [31:0] faddr_next, fdata_next, fpc_next, cycle_next;
  logic [31:0] exp_addr, exp_data;

  // Milestone table indexed by how many entries have already been matched
  always_comb begin
    exp_addr = CHECK_ADDR0;
    exp_data = CHECK_DATA0;
    case (hit_count[1:0])
      2'd1:    begin exp_addr = CHECK_ADDR1; exp_data = CHECK_DATA1; end
      2'd2:    begin exp_addr = CHECK_ADDR2; exp_data = CHECK_DATA2; end
      2'd3:    begin exp_addr = CHECK_ADDR3; exp_data = CHECK_DATA3; end
      default: begin exp_addr = CHECK_ADDR0; exp_data = CHECK_DATA0; end
    endcase
  end

  always_comb begin
    state_next     = state;
    hit_next       = hit_count;
    milestone_next = 1'b0;
    code_next      = fail_code;
    faddr_next     = fail_addr;
    fdata_next     = fail_data;
    fpc_next       = fail_pc;
    cycle_next     = cycle_count;

    if (state == ST_RUN) begin
      if (cycle_count != 32'hFFFF_FFFF) begin
        cycle_next = cycle_count + 32'd1;
      end

      if (memwrite) begin
        if (dataaddr != exp_addr) begin
          state_next = ST_FAIL;
          code_next  = CODE_ADDR;
          faddr_next = dataaddr;
          fdata_next = writedata;
          fpc_next   = pc;
        end else if (writedata != exp_data) begin
          state_next = ST_FAIL;
          code_next  = CODE_DATA;
          faddr_next = dataaddr;
          fdata_next = writedata;
          fpc_next   = pc;
        end else begin
          hit_next       = hit_count + 3'd1;
          milestone_next = 1'b1;
          if (hit_next == LAST_HIT) begin
            state_next = ST_PASS;
          end
        end
      end

`ifdef MEM_CHECK_TIMEOUT_EN
      // A store that already decided the outcome this edge takes priority
      if (state_next == ST_RUN && cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
        state_next = ST_FAIL;
        code_next  = CODE_TIMEOUT;
        faddr_next = 32'd0;
        fdata_next = 32'd0;
        fpc_next   = pc;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      hit_count   <= 3'd0;
      milestone   <= 1'b0;
      fail_code   <= CODE_NONE;
      fail_addr   <= 32'd0;
      fail_data   <= 32'd0;
      fail_pc     <= 32'd0;
      cycle_count <= 32'd0;
    end else begin
      state       <= state_next;
      hit_count   <= hit_next;
      milestone   <= milestone_next;
      fail_code   <= code_next;
      fail_addr   <= faddr_next;
      fail_data   <= fdata_next;
      fail_pc     <= fpc_next;
      cycle_count <= cycle_next;
    end
  end

  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);
  assign done = pass | fail;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ============================================================================
// Module   : tb_mem_write_checker
// Purpose  : Directed self-checking bench for mem_write_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataaddr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        done, pass, fail, milestone;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data, fail_pc, cycle_count;
  logic [2:0]  hit_count;

  int tests_run = 0;
  int tests_failed = 0;

  mem_write_checker #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
    .writedata(writedata), .pc(pc), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_pc(fail_pc), .hit_count(hit_count), .milestone(milestone),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Leaves reset deasserted at a falling edge; the next rising edge is cycle 0
  task automatic do_reset();
    reset = 1'b1;
    memwrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    memwrite = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    memwrite = 1'b1;
    dataaddr = a;
    writedata = d;
    pc = p;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if ({done, pass, fail, fail_code, hit_count, milestone} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 0", {done, pass, fail, fail_code, hit_count, milestone});
    end
    tests_run++;
    if ({fail_addr, fail_data, fail_pc, cycle_count} !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h required 0", {fail_addr, fail_data, fail_pc, cycle_count});
    end
  endtask

  task automatic test_pass_sequence();
    do_reset();
    idle(10);
    store(32'd80, 32'd7, 32'h10);
    tests_run++;
    if (milestone !== 1'b1 || hit_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL pass_hit1: got ms=%b hit=%0d required ms=1 hit=1", milestone, hit_count);
    end
    idle(1);
    tests_run++;
    if (milestone !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_ms_pulse: got %b required 0", milestone);
    end
    idle(8);
    store(32'd84, 32'd7, 32'h20);
    tests_run++;
    if (milestone !== 1'b1 || hit_count !== 3'd2 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_hit2: got ms=%b hit=%0d done=%b required 1/2/0", milestone, hit_count, done);
    end
    idle(9);
    store(32'd88, 32'd9, 32'h30);
    tests_run++;
    if (pass !== 1'b1 || done !== 1'b1 || fail !== 1'b0 || hit_count !== 3'd3 || milestone !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_final: got pass=%b done=%b fail=%b hit=%0d ms=%b required 1/1/0/3/1",
               pass, done, fail, hit_count, milestone);
    end
    tests_run++;
    if (cycle_count !== 32'd31) begin
      tests_failed++;
      $display("FAIL pass_cycles: got %0d required 31", cycle_count);
    end
    store(32'd100, 32'd1, 32'h40);
    idle(2);
    tests_run++;
    if (pass !== 1'b1 || fail !== 1'b0 || fail_code !== 2'd0 || milestone !== 1'b0 ||
        cycle_count !== 32'd31 || hit_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL pass_sticky: got pass=%b fail=%b code=%0d ms=%b cyc=%0d hit=%0d required 1/0/0/0/31/3",
               pass, fail, fail_code, milestone, cycle_count, hit_count);
    end
  endtask

  task automatic test_data_mismatch();
    do_reset();
    store(32'd80, 32'd7, 32'h100);
    store(32'd84, 32'd5, 32'h1234);
    tests_run++;
    if (fail !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd2) begin
      tests_failed++;
      $display("FAIL data_flags: got fail=%b done=%b pass=%b code=%0d required 1/1/0/2", fail, done, pass, fail_code);
    end
    tests_run++;
    if (fail_addr !== 32'd84 || fail_data !== 32'd5 || fail_pc !== 32'h1234 || hit_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL data_capture: got addr=%0d data=%0d pc=%h hit=%0d required 84/5/1234/1",
               fail_addr, fail_data, fail_pc, hit_count);
    end
    store(32'd88, 32'd9, 32'h2000);
    idle(3);
    tests_run++;
    if (cycle_count !== 32'd2 || fail_addr !== 32'd84 || fail_pc !== 32'h1234 || milestone !== 1'b0) begin
      tests_failed++;
      $display("FAIL data_frozen: got cyc=%0d addr=%0d pc=%h ms=%b required 2/84/1234/0",
               cycle_count, fail_addr, fail_pc, milestone);
    end
  endtask

  task automatic test_bad_address();
    do_reset();
    dataaddr = 32'd100;
    idle(5);
    tests_run++;
    if (fail !== 1'b0 || cycle_count !== 32'd5) begin
      tests_failed++;
      $display("FAIL idle_ignored: got fail=%b cyc=%0d required 0/5", fail, cycle_count);
    end
    store(32'd100, 32'd7, 32'h44);
    tests_run++;
    if (fail_code !== 2'd1 || fail_addr !== 32'd100 || fail_data !== 32'd7 || hit_count !== 3'd0 || fail !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_addr: got code=%0d addr=%0d data=%0d hit=%0d fail=%b required 1/100/7/0/1",
               fail_code, fail_addr, fail_data, hit_count, fail);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    store(32'd84, 32'd7, 32'h8);
    tests_run++;
    if (fail_code !== 2'd1 || fail_addr !== 32'd84 || hit_count !== 3'd0 || milestone !== 1'b0) begin
      tests_failed++;
      $display("FAIL out_of_order: got code=%0d addr=%0d hit=%0d ms=%b required 1/84/0/0",
               fail_code, fail_addr, hit_count, milestone);
    end
    do_reset();
    store(32'h0001_0050, 32'd7, 32'h8);
    tests_run++;
    if (fail_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL full_width_addr: got code=%0d required 1", fail_code);
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    store(32'd80, 32'd7, 32'h4);
    tests_run++;
    if (hit_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL mid_hit: got %0d required 1", hit_count);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({done, pass, fail, fail_code, hit_count, milestone} !== 9'd0 || cycle_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got flags=%b cyc=%0d required 0/0",
               {done, pass, fail, fail_code, hit_count, milestone}, cycle_count);
    end
    @(negedge clk);
    reset = 1'b0;
    store(32'd80, 32'd7, 32'h4);
    store(32'd84, 32'd7, 32'h8);
    tests_run++;
    if (milestone !== 1'b1 || hit_count !== 3'd2) begin
      tests_failed++;
      $display("FAIL b2b_hit2: got ms=%b hit=%0d required 1/2", milestone, hit_count);
    end
    store(32'd88, 32'd9, 32'hC);
    tests_run++;
    if (pass !== 1'b1 || milestone !== 1'b1 || cycle_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL b2b_pass: got pass=%b ms=%b cyc=%0d required 1/1/3", pass, milestone, cycle_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pc = 32'hABCD;
    dataaddr = 32'd5;
    writedata = 32'd6;
`ifdef MEM_CHECK_TIMEOUT_EN
    idle(49);
    tests_run++;
    if (fail !== 1'b0 || cycle_count !== 32'd49) begin
      tests_failed++;
      $display("FAIL timeout_early: got fail=%b cyc=%0d required 0/49", fail, cycle_count);
    end
    idle(1);
    tests_run++;
    if (fail !== 1'b1 || fail_code !== 2'd3 || fail_addr !== 32'd0 || fail_data !== 32'd0 ||
        fail_pc !== 32'hABCD || cycle_count !== 32'd50) begin
      tests_failed++;
      $display("FAIL timeout: got fail=%b code=%0d addr=%0d data=%0d pc=%h cyc=%0d required 1/3/0/0/abcd/50",
               fail, fail_code, fail_addr, fail_data, fail_pc, cycle_count);
    end
`else
    idle(200);
    tests_run++;
    if (fail !== 1'b0 || done !== 1'b0 || fail_code !== 2'd0 || cycle_count !== 32'd200) begin
      tests_failed++;
      $display("FAIL no_watchdog: got fail=%b done=%b code=%0d cyc=%0d required 0/0/0/200",
               fail, done, fail_code, cycle_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_sequence();
    test_data_mismatch();
    test_bad_address();
    test_out_of_order();
    test_reset_mid_check();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
